// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
package data_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Bits needed to hold the values 0..n inclusive, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = data_mem_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = data_mem_pkg::DEF_DATA_WIDTH
) ();
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter_starve.sv
// Saturating count of arbitrations the DMA has lost in a row; clear wins over increment.
// Count is visible the cycle after the event; no backpressure.
module arb_starve_counter
    import data_mem_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (fixed priority) and the DMA.
// Writes finish in the arbitration cycle, reads after MEM_LATENCY more; losers are held off via cpu_stall / withheld dma_gnt.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = cnt_width(MAX_WAIT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_WAIT);

    arb_state_t            state_q, state_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic [STV_W-1:0]      starve_cnt;
    owner_t                winner;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  cpu_done, dma_done;

    // Arbitration only in IDLE; reset suppresses every grant so no command leaks out.
    always_comb begin
        winner = OWN_NONE;
        if (!rst && (state_q == IDLE)) begin
            if (bus.dma_req && (!bus.cpu_req || (starve_cnt == STV_MAX))) begin
                winner = OWN_DMA;
            end else if (bus.cpu_req) begin
                winner = OWN_CPU;
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = bus.cpu_addr;
        win_wdata = bus.cpu_wdata;
        if (winner == OWN_DMA) begin
            win_we    = bus.dma_we;
            win_addr  = bus.dma_addr;
            win_wdata = bus.dma_wdata;
        end else if (winner == OWN_CPU) begin
            win_we    = bus.cpu_we;
        end
    end

    assign cpu_done = !rst && (state_q == RD_CPU) && (lat_cnt_q == '0);
    assign dma_done = !rst && (state_q == RD_DMA) && (lat_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if ((winner != OWN_NONE) && !win_we) begin
                    state_d   = (winner == OWN_DMA) ? RD_DMA : RD_CPU;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            RD_CPU, RD_DMA: begin
                if (lat_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (cpu_done) cpu_rdata_d = bus.mem_rdata;
        if (dma_done) dma_rdata_d = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    arb_starve_counter #(
        .MAX (MAX_WAIT),
        .W   (STV_W)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc ((winner == OWN_CPU) && bus.dma_req),
        .clr (winner == OWN_DMA),
        .cnt (starve_cnt)
    );

    assign bus.mem_en    = (winner != OWN_NONE);
    assign bus.mem_we    = win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;

    assign bus.dma_gnt    = (winner == OWN_DMA);
    assign bus.dma_rvalid = dma_done;
    // Read data is forwarded in the completion cycle, then held from the register.
    assign bus.dma_rdata  = dma_done ? bus.mem_rdata : dma_rdata_q;
    assign bus.cpu_rdata  = cpu_done ? bus.mem_rdata : cpu_rdata_q;

    assign bus.cpu_stall = !rst && bus.cpu_req
                           && !(cpu_done || ((winner == OWN_CPU) && bus.cpu_we));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with directed traffic and checks them each cycle against a transaction-level model.
module tb_data_mem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int LAT [2] = '{1, 3};

    typedef struct packed {
        logic        cpu_req;
        logic        cpu_we;
        logic [15:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [15:0] dma_addr;
        logic [31:0] dma_wdata;
    } req_t;

    typedef struct packed {
        logic        cpu_stall;
        logic [31:0] cpu_rdata;
        logic        dma_gnt;
        logic        dma_rvalid;
        logic [31:0] dma_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) b1 ();
    data_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) b3 ();

    data_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_WAIT(MAX_WAIT))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    data_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(3), .MAX_WAIT(MAX_WAIT))
        dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    // Memories: index 0 behind dut1, index 1 behind dut3.
    logic [31:0] mem [2][65536];
    logic        pl_vld = 1'b0;
    int          pl_k = 0;
    logic [15:0] pl_a = '0;
    logic [31:0] pl_d = '0;
    logic [15:0] ra1;
    logic        rv1 = 1'b0;
    logic [15:0] ra3 [3];
    logic        rv3 [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        if (pl_vld) mem[pl_k][pl_a] <= pl_d;
        if (b1.mem_en && b1.mem_we) mem[0][b1.mem_addr] <= b1.mem_wdata;
        if (b3.mem_en && b3.mem_we) mem[1][b3.mem_addr] <= b3.mem_wdata;
        ra1    <= b1.mem_addr;
        rv1    <= b1.mem_en && !b1.mem_we;
        ra3[0] <= b3.mem_addr;
        rv3[0] <= b3.mem_en && !b3.mem_we;
        ra3[1] <= ra3[0];
        rv3[1] <= rv3[0];
        ra3[2] <= ra3[1];
        rv3[2] <= rv3[1];
    end

    assign b1.mem_rdata = rv1    ? mem[0][ra1]    : 32'hBAD0BAD0;
    assign b3.mem_rdata = rv3[2] ? mem[1][ra3[2]] : 32'hBAD0BAD0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s @%0t: no response within cycle budget", nm, $time);
    endtask

    function automatic req_t get_req(input int k);
        req_t r;
        if (k == 0) begin
            r.cpu_req = b1.cpu_req;  r.cpu_we = b1.cpu_we;  r.cpu_addr = b1.cpu_addr;  r.cpu_wdata = b1.cpu_wdata;
            r.dma_req = b1.dma_req;  r.dma_we = b1.dma_we;  r.dma_addr = b1.dma_addr;  r.dma_wdata = b1.dma_wdata;
        end else begin
            r.cpu_req = b3.cpu_req;  r.cpu_we = b3.cpu_we;  r.cpu_addr = b3.cpu_addr;  r.cpu_wdata = b3.cpu_wdata;
            r.dma_req = b3.dma_req;  r.dma_we = b3.dma_we;  r.dma_addr = b3.dma_addr;  r.dma_wdata = b3.dma_wdata;
        end
        return r;
    endfunction

    function automatic rsp_t get_rsp(input int k);
        rsp_t o;
        if (k == 0) begin
            o.cpu_stall = b1.cpu_stall; o.cpu_rdata = b1.cpu_rdata; o.dma_gnt = b1.dma_gnt;
            o.dma_rvalid = b1.dma_rvalid; o.dma_rdata = b1.dma_rdata; o.mem_en = b1.mem_en;
            o.mem_we = b1.mem_we; o.mem_addr = b1.mem_addr; o.mem_wdata = b1.mem_wdata;
        end else begin
            o.cpu_stall = b3.cpu_stall; o.cpu_rdata = b3.cpu_rdata; o.dma_gnt = b3.dma_gnt;
            o.dma_rvalid = b3.dma_rvalid; o.dma_rdata = b3.dma_rdata; o.mem_en = b3.mem_en;
            o.mem_we = b3.mem_we; o.mem_addr = b3.mem_addr; o.mem_wdata = b3.mem_wdata;
        end
        return o;
    endfunction

    // Transaction model: who owns the memory, until which cycle, and how often the DMA lost.
    bit          m_owned   [2] = '{0, 0};
    bit          m_own_dma [2] = '{0, 0};
    int          m_done_at [2] = '{0, 0};
    logic [15:0] m_raddr   [2] = '{16'h0, 16'h0};
    int          m_starve  [2] = '{0, 0};
    logic [31:0] m_cpu_hold[2] = '{32'h0, 32'h0};
    logic [31:0] m_dma_hold[2] = '{32'h0, 32'h0};

    task automatic model_check(input int k, input req_t r, input rsp_t o);
        logic e_en, e_we, e_gnt, e_rv, e_stall, done, cpu_w, dma_w;
        logic [15:0] e_addr;
        logic [31:0] e_wd, e_crd, e_drd;
        string tag;
        e_en = 0; e_we = 0; e_gnt = 0; e_rv = 0; e_stall = 0; done = 0; cpu_w = 0; dma_w = 0;
        e_addr = '0; e_wd = '0; e_crd = m_cpu_hold[k]; e_drd = m_dma_hold[k];
        tag = $sformatf("u%0d c%0d", k, cyc);
        if (rst) begin
            m_owned[k]  = 0;
            m_starve[k] = 0;
        end else if (m_owned[k]) begin
            done = (cyc == m_done_at[k]);
            if (done) begin
                if (m_own_dma[k]) begin
                    e_rv  = 1;
                    e_drd = mem[k][m_raddr[k]];
                end else begin
                    e_crd = mem[k][m_raddr[k]];
                end
                m_owned[k] = 0;
            end
            e_stall = r.cpu_req && !(done && !m_own_dma[k]);
        end else begin
            dma_w = r.dma_req && (!r.cpu_req || (m_starve[k] == MAX_WAIT));
            cpu_w = r.cpu_req && !dma_w;
            if (dma_w) begin
                e_en = 1; e_gnt = 1; e_we = r.dma_we; e_addr = r.dma_addr; e_wd = r.dma_wdata;
                m_starve[k] = 0;
            end else if (cpu_w) begin
                e_en = 1; e_we = r.cpu_we; e_addr = r.cpu_addr; e_wd = r.cpu_wdata;
                if (r.dma_req && (m_starve[k] < MAX_WAIT)) m_starve[k]++;
            end
            if (e_en && !e_we) begin
                m_owned[k]   = 1;
                m_own_dma[k] = dma_w;
                m_raddr[k]   = e_addr;
                m_done_at[k] = cyc + LAT[k];
            end
            e_stall = r.cpu_req && !(cpu_w && r.cpu_we);
        end
        chk({tag, " cpu_stall"},  o.cpu_stall,  e_stall);
        chk({tag, " dma_gnt"},    o.dma_gnt,    e_gnt);
        chk({tag, " dma_rvalid"}, o.dma_rvalid, e_rv);
        chk({tag, " cpu_rdata"},  o.cpu_rdata,  e_crd);
        chk({tag, " dma_rdata"},  o.dma_rdata,  e_drd);
        chk({tag, " mem_en"},     o.mem_en,     e_en);
        if (e_en) begin
            chk({tag, " mem_we"},   o.mem_we,   e_we);
            chk({tag, " mem_addr"}, o.mem_addr, e_addr);
            if (e_we) chk({tag, " mem_wdata"}, o.mem_wdata, e_wd);
        end
        m_cpu_hold[k] = rst ? 32'h0 : e_crd;
        m_dma_hold[k] = rst ? 32'h0 : e_drd;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_check(0, get_req(0), get_rsp(0));
            model_check(1, get_req(1), get_rsp(1));
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input int k, input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
        if (k == 0) begin b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d; end
        else        begin b3.cpu_req = req; b3.cpu_we = we; b3.cpu_addr = a; b3.cpu_wdata = d; end
    endtask

    task automatic set_dma(input int k, input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
        if (k == 0) begin b1.dma_req = req; b1.dma_we = we; b1.dma_addr = a; b1.dma_wdata = d; end
        else        begin b3.dma_req = req; b3.dma_we = we; b3.dma_addr = a; b3.dma_wdata = d; end
    endtask

    task automatic preload(input int k, input logic [15:0] a, input logic [31:0] d);
        pl_k = k; pl_a = a; pl_d = d; pl_vld = 1'b1;
        step();
        pl_vld = 1'b0;
    endtask

    task automatic cpu_access(input int k, input logic we, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        bit   ok;
        rsp_t o;
        ok = 0;
        rd = '0;
        set_cpu(k, 1'b1, we, a, d);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            o = get_rsp(k);
            if (!o.cpu_stall) begin ok = 1; rd = o.cpu_rdata; break; end
            step();
        end
        if (!ok) timeout("cpu_access");
        step();
        set_cpu(k, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic dma_access(input int k, input logic we, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        bit   ok;
        rsp_t o;
        ok = 0;
        rd = '0;
        set_dma(k, 1'b1, we, a, d);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            o = get_rsp(k);
            if (o.dma_gnt) begin ok = 1; break; end
            step();
        end
        if (!ok) timeout("dma_access grant");
        step();
        set_dma(k, 1'b0, 1'b0, 16'h0, 32'h0);
        if (!we) begin
            ok = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                o = get_rsp(k);
                if (o.dma_rvalid) begin ok = 1; rd = o.dma_rdata; break; end
                step();
            end
            if (!ok) timeout("dma_access rvalid");
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int gnt_cyc, cpu_wins, rv_seen;

        rst = 1'b1;
        set_cpu(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        set_dma(0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_cpu(1, 1'b0, 1'b0, 16'h0, 32'h0);
        set_dma(1, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        chk_en = 1'b1;

        // Reset state, including stall forced low despite a pending CPU request.
        @(negedge clk);
        chk("rst cpu_stall", b1.cpu_stall, 1'b0);
        chk("rst mem_en",    b1.mem_en,    1'b0);
        chk("rst cpu_rdata", b1.cpu_rdata, 32'h0);
        chk("rst dma_rdata", b3.dma_rdata, 32'h0);
        step();
        set_cpu(0, 1'b0, 1'b0, 16'h0, 32'h0);
        preload(0, 16'h0010, 32'hDEADBEEF);
        preload(0, 16'h0030, 32'h30303030);
        preload(0, 16'h0040, 32'h40404040);
        preload(1, 16'h0100, 32'h000000FF);
        preload(1, 16'h0108, 32'hCAFEF00D);
        preload(1, 16'h0110, 32'h0BADCAFE);

        // CPU read, latency 1.
        rst = 1'b0;
        set_cpu(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        chk("t1 mem_en at T",    b1.mem_en,    1'b1);
        chk("t1 cpu_stall at T", b1.cpu_stall, 1'b1);
        step();
        @(negedge clk);
        chk("t1 cpu_stall at T+1", b1.cpu_stall, 1'b0);
        chk("t1 cpu_rdata",        b1.cpu_rdata, 32'hDEADBEEF);
        step();
        set_cpu(0, 1'b0, 1'b0, 16'h0, 32'h0);

        // CPU write completes in the arbitration cycle, then read it back.
        set_cpu(0, 1'b1, 1'b1, 16'h0020, 32'h12345678);
        @(negedge clk);
        chk("t2 mem_en",    b1.mem_en,    1'b1);
        chk("t2 mem_we",    b1.mem_we,    1'b1);
        chk("t2 cpu_stall", b1.cpu_stall, 1'b0);
        step();
        set_cpu(0, 1'b0, 1'b0, 16'h0, 32'h0);
        cpu_access(0, 1'b0, 16'h0020, 32'h0, rd);
        chk("t2 readback", rd, 32'h12345678);

        // Both requesters hold read requests: CPU wins four times, then the DMA.
        set_cpu(0, 1'b1, 1'b0, 16'h0030, 32'h0);
        set_dma(0, 1'b1, 1'b0, 16'h0040, 32'h0);
        gnt_cyc = -1;
        cpu_wins = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b1.mem_en && !b1.dma_gnt && (gnt_cyc < 0)) cpu_wins++;
            if (b1.dma_gnt && (gnt_cyc < 0)) gnt_cyc = c;
            if (c == 8) chk("t3 stall during dma issue", b1.cpu_stall, 1'b1);
            if (c == 9) chk("t3 dma_rdata", b1.dma_rdata, 32'h40404040);
            step();
            if (c == gnt_cyc) set_dma(0, 1'b0, 1'b0, 16'h0, 32'h0);
        end
        set_cpu(0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("t3 dma grant cycle",   gnt_cyc,  32'd8);
        chk("t3 cpu wins first",    cpu_wins, 32'd4);
        chk("t3 cpu_rdata",         b1.cpu_rdata, 32'h30303030);

        // DMA read at latency 3; a follow-up request waits for the memory.
        set_dma(1, 1'b1, 1'b0, 16'h0100, 32'h0);
        @(negedge clk);
        chk("t4 gnt at T", b3.dma_gnt, 1'b1);
        step();
        set_dma(1, 1'b1, 1'b1, 16'h0104, 32'hA5A5A5A5);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t4 rvalid T+%0d", i), b3.dma_rvalid, (i == 3));
            chk($sformatf("t4 gnt T+%0d", i),    b3.dma_gnt,    (i == 4));
            if (i == 3) chk("t4 dma_rdata", b3.dma_rdata, 32'h000000FF);
            step();
        end
        set_dma(1, 1'b0, 1'b0, 16'h0, 32'h0);
        step();

        // Reset one cycle into a latency-3 DMA read abandons it.
        set_dma(1, 1'b1, 1'b0, 16'h0100, 32'h0);
        @(negedge clk);
        chk("t5 gnt", b3.dma_gnt, 1'b1);
        step();
        set_dma(1, 1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rvalid in reset", b3.dma_rvalid, 1'b0);
        step();
        rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rv_seen += int'(b3.dma_rvalid);
            if (i == 0) chk("t5 mem_en after reset", b3.mem_en, 1'b0);
            step();
        end
        chk("t5 no rvalid after reset", rv_seen, 32'd0);
        dma_access(1, 1'b0, 16'h0108, 32'h0, rd);
        chk("t5 new dma read", rd, 32'hCAFEF00D);

        // Simultaneous writes: CPU first, DMA granted next cycle.
        set_cpu(0, 1'b1, 1'b1, 16'h0050, 32'h11111111);
        set_dma(0, 1'b1, 1'b1, 16'h0060, 32'h22222222);
        @(negedge clk);
        chk("t6 cpu_stall", b1.cpu_stall, 1'b0);
        chk("t6 dma_gnt T", b1.dma_gnt,   1'b0);
        chk("t6 addr T",    b1.mem_addr,  16'h0050);
        step();
        set_cpu(0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        chk("t6 dma_gnt T+1", b1.dma_gnt,  1'b1);
        chk("t6 addr T+1",    b1.mem_addr, 16'h0060);
        step();
        set_dma(0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        chk("t6 mem cpu word", mem[0][16'h0050], 32'h11111111);
        chk("t6 mem dma word", mem[0][16'h0060], 32'h22222222);

        // CPU drops its request mid-read; the read still completes.
        set_cpu(1, 1'b1, 1'b0, 16'h0110, 32'h0);
        @(negedge clk);
        chk("t7 stall at issue", b3.cpu_stall, 1'b1);
        step();
        set_cpu(1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        chk("t7 stall after drop", b3.cpu_stall, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("t7 cpu_rdata", b3.cpu_rdata, 32'h0BADCAFE);
        step();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
